// File: rtl/multicycle_ctrl_hs_pkg.sv
// Shared state encodings and trap cause codes for the multi-cycle RV32 control FSM.
package multicycle_ctrl_hs_pkg;

  typedef enum logic [2:0] {
    ST_IF    = 3'd0,
    ST_ID_EX = 3'd1,
    ST_MEM   = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4,
    ST_TRAP  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_IMEM_TO = 2'd2,
    CAUSE_DMEM_TO = 2'd3
  } trap_cause_t;

  // States that wait on a memory ready and are covered by the watchdog.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_IF) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Wait-state watchdog: counts not-ready cycles and flags the last permitted one.
module ctrl_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  localparam int               LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(LAST_I);

  logic [CNT_W-1:0] wait_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (count_en && (wait_cnt != '1)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
      assign expire = count_en && (wait_cnt == LAST);
    end else begin : g_no_wdog
      assign expire = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/multicycle_ctrl_hs.sv
// Multi-cycle RV32 control FSM: IF -> ID_EX -> [MEM] -> WB with memory handshakes,
// wait-state watchdog, illegal-instruction trap and halt/resume.
module multicycle_ctrl_hs
  import multicycle_ctrl_hs_pkg::*;
#(
  parameter int DMEM_WE_W      = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 load,
  input  logic                 store,
  input  logic                 branch,
  input  logic                 fence,
  input  logic                 halt,
  input  logic                 illegal,
  input  logic [DMEM_WE_W-1:0] decoder_dmem_we,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  input  logic                 resume,
  output logic                 pc_we,
  output logic                 imem_rd,
  output logic                 rf_we,
  output logic [DMEM_WE_W-1:0] dmem_we,
  output logic                 dmem_rd,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [2:0]           state_o
);

  state_t      state, next_state;
  trap_cause_t cause_q, next_cause;
  logic        wait_ready;
  logic        expire;

  assign wait_ready = (state == ST_IF) ? imem_ready : dmem_ready;

  // IF and MEM are never adjacent, so holding the counter clear outside them
  // gives a fresh count on every entry.
  ctrl_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (!is_wait_state(state)),
    .count_en(is_wait_state(state) && !wait_ready),
    .expire  (expire)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IF;
      cause_q <= CAUSE_NONE;
    end else begin
      state   <= next_state;
      cause_q <= next_cause;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    next_cause = cause_q;
    case (state)
      ST_IF: begin
        if (imem_ready) begin
          next_state = ST_ID_EX;
        end else if (expire) begin
          next_state = ST_TRAP;
          next_cause = CAUSE_IMEM_TO;
        end
      end
      ST_ID_EX: begin
        if (illegal) begin
          next_state = ST_TRAP;
          next_cause = CAUSE_ILLEGAL;
        end else if (halt) begin
          next_state = ST_HALT;
        end else if (load || store) begin
          next_state = ST_MEM;
        end else begin
          next_state = ST_WB;
        end
      end
      ST_MEM: begin
        if (dmem_ready) begin
          next_state = ST_WB;
        end else if (expire) begin
          next_state = ST_TRAP;
          next_cause = CAUSE_DMEM_TO;
        end
      end
      ST_WB:   next_state = ST_IF;
      ST_HALT: next_state = resume ? ST_IF : ST_HALT;
      ST_TRAP: next_state = ST_TRAP;
      default: next_state = ST_IF;
    endcase
  end

  always_comb begin
    pc_we   = 1'b0;
    imem_rd = 1'b0;
    rf_we   = 1'b0;
    dmem_we = '0;
    dmem_rd = 1'b0;
    trap    = 1'b0;
    case (state)
      ST_IF:   imem_rd = 1'b1;
      ST_MEM: begin
        // A load takes priority if the decoder flags both.
        dmem_rd = load;
        dmem_we = (store && !load) ? decoder_dmem_we : '0;
      end
      ST_WB: begin
        pc_we = 1'b1;
        rf_we = !(store || branch || fence);
      end
      ST_HALT: pc_we = resume;
      ST_TRAP: trap  = 1'b1;
      default: ;
    endcase
  end

  assign trap_cause = cause_q;
  assign state_o    = state;

endmodule

// File: tb/tb_multicycle_ctrl_hs.sv
// Self-checking bench: a transaction-level model expands each instruction into
// its expected per-cycle outputs, which are compared against the DUT.
module tb_multicycle_ctrl_hs;

  localparam int T = 4;
  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_MEM = 3'd2, S_WB = 3'd3,
                         S_HALT = 3'd4, S_TRAP = 3'd5;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       load, store, branch, fence, halt, illegal;
  logic [3:0] decoder_dmem_we;
  logic       imem_ready, dmem_ready, resume;
  logic       pc_we, imem_rd, rf_we, dmem_rd, trap;
  logic [3:0] dmem_we;
  logic [1:0] trap_cause;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  multicycle_ctrl_hs #(.DMEM_WE_W(4), .TIMEOUT_CYCLES(T), .CNT_W(3)) dut (
    .clk(clk), .rstn(rstn), .load(load), .store(store), .branch(branch),
    .fence(fence), .halt(halt), .illegal(illegal), .decoder_dmem_we(decoder_dmem_we),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .resume(resume),
    .pc_we(pc_we), .imem_rd(imem_rd), .rf_we(rf_we), .dmem_we(dmem_we),
    .dmem_rd(dmem_rd), .trap(trap), .trap_cause(trap_cause), .state_o(state_o)
  );

  typedef struct packed {
    logic load, store, branch, fence, halt, illegal;
    logic [3:0] we;
    logic imem_ready, dmem_ready, resume;
  } stim_t;

  typedef struct packed {
    logic [2:0] st;
    logic imem_rd, pc_we, rf_we, dmem_rd;
    logic [3:0] dmem_we;
    logic trap;
    logic [1:0] cause;
  } obs_t;

  typedef struct packed { stim_t s; obs_t e; } cyc_t;

  typedef enum int {K_ALU, K_BRANCH, K_FENCE, K_LOAD, K_STORE, K_LDST, K_HALT,
                    K_ILL, K_ILL_HALT} kind_t;

  cyc_t       q[$];
  logic [1:0] m_cause = 2'd0;
  int         n_tests = 0;
  int         n_fail  = 0;

  // ---------------- reference model ----------------
  function automatic stim_t garbage();
    logic [31:0] r;
    r = $urandom;
    return r[$bits(stim_t)-1:0];
  endfunction

  function automatic obs_t mk(logic [2:0] st, logic ird, logic pcw, logic rfw,
                              logic drd, logic [3:0] dwe);
    obs_t e;
    e.st = st; e.imem_rd = ird; e.pc_we = pcw; e.rf_we = rfw;
    e.dmem_rd = drd; e.dmem_we = dwe; e.trap = (st == S_TRAP); e.cause = m_cause;
    return e;
  endfunction

  task automatic add_trap(input logic [1:0] c);
    m_cause = c;
    repeat (3) q.push_back('{garbage(), mk(S_TRAP, 0, 0, 0, 0, 4'h0)});
  endtask

  task automatic add_instr(input kind_t k, input int wi, input int wd,
                           input int hold, input logic [3:0] we);
    logic  ld, st, br, fe, ha, il;
    stim_t s, dec;
    ld = k inside {K_LOAD, K_LDST};
    st = k inside {K_STORE, K_LDST};
    br = (k == K_BRANCH);
    fe = (k == K_FENCE);
    ha = k inside {K_HALT, K_ILL_HALT};
    il = k inside {K_ILL, K_ILL_HALT};
    for (int i = 0; i <= wi; i++) begin
      s = garbage();
      s.imem_ready = (i == wi);
      q.push_back('{s, mk(S_IF, 1, 0, 0, 0, 4'h0)});
      if (i != wi && i == T - 1) begin add_trap(2'd2); return; end
    end
    dec = garbage();
    dec.load = ld; dec.store = st; dec.branch = br; dec.fence = fe;
    dec.halt = ha; dec.illegal = il; dec.we = we;
    q.push_back('{dec, mk(S_ID, 0, 0, 0, 0, 4'h0)});
    if (il) begin add_trap(2'd1); return; end
    if (ha) begin
      for (int h = 0; h < hold; h++) begin
        s = dec; s.imem_ready = 1'($urandom); s.resume = 1'b0;
        q.push_back('{s, mk(S_HALT, 0, 0, 0, 0, 4'h0)});
      end
      s = dec; s.resume = 1'b1;
      q.push_back('{s, mk(S_HALT, 0, 1, 0, 0, 4'h0)});
      return;
    end
    if (ld || st) begin
      for (int i = 0; i <= wd; i++) begin
        s = dec; s.imem_ready = 1'($urandom); s.resume = 1'($urandom);
        s.dmem_ready = (i == wd);
        q.push_back('{s, mk(S_MEM, 0, 0, 0, ld, (st && !ld) ? we : 4'h0)});
        if (i != wd && i == T - 1) begin add_trap(2'd3); return; end
      end
    end
    s = dec; s.imem_ready = 1'($urandom); s.resume = 1'($urandom);
    q.push_back('{s, mk(S_WB, 0, 1, !(st || br || fe), 0, 4'h0)});
  endtask

  // ---------------- drivers ----------------
  task automatic apply(input stim_t s);
    load = s.load; store = s.store; branch = s.branch; fence = s.fence;
    halt = s.halt; illegal = s.illegal; decoder_dmem_we = s.we;
    imem_ready = s.imem_ready; dmem_ready = s.dmem_ready; resume = s.resume;
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.st = state_o; o.imem_rd = imem_rd; o.pc_we = pc_we; o.rf_we = rf_we;
    o.dmem_rd = dmem_rd; o.dmem_we = dmem_we; o.trap = trap; o.cause = trap_cause;
    return o;
  endfunction

  // Called at posedge+1; returns the outputs seen at the following negedge.
  task automatic drive_cycle(input stim_t s, output obs_t o);
    apply(s);
    @(negedge clk);
    o = observe();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset(input string tag);
    obs_t o, e;
    rstn = 1'b0;
    m_cause = 2'd0;
    apply(garbage());
    e = mk(S_IF, 1, 0, 0, 0, 4'h0);
    #2;
    o = observe();
    n_tests++;
    if (o !== e) begin
      n_fail++; $display("FAIL reset_%s async: got %h want %h", tag, o, e);
    end
    @(posedge clk);
    @(negedge clk);
    o = observe();
    n_tests++;
    if (o !== e) begin
      n_fail++; $display("FAIL reset_%s held: got %h want %h", tag, o, e);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_alu();
    cyc_t c; obs_t o; int n = 0;
    add_instr(K_ALU, 0, 0, 0, 4'h0);
    add_instr(K_ALU, 0, 0, 0, 4'h0);
    while (q.size() > 0) begin
      c = q.pop_front(); drive_cycle(c.s, o); n_tests++;
      if (o !== c.e) begin n_fail++; $display("FAIL alu cycle %0d: got %h want %h", n, o, c.e); end
      n++;
    end
  endtask

  task automatic test_store_wait();
    cyc_t c; obs_t o; int n = 0;
    add_instr(K_STORE, 0, 2, 0, 4'b0011);
    add_instr(K_LDST, 1, 1, 0, 4'b1111);
    while (q.size() > 0) begin
      c = q.pop_front(); drive_cycle(c.s, o); n_tests++;
      if (o !== c.e) begin n_fail++; $display("FAIL store_wait cycle %0d: got %h want %h", n, o, c.e); end
      n++;
    end
  endtask

  task automatic test_imem_boundary();
    cyc_t c; obs_t o; int n = 0;
    add_instr(K_BRANCH, T - 1, 0, 0, 4'h0);
    add_instr(K_LOAD, 0, T - 1, 0, 4'h0);
    while (q.size() > 0) begin
      c = q.pop_front(); drive_cycle(c.s, o); n_tests++;
      if (o !== c.e) begin n_fail++; $display("FAIL ready_boundary cycle %0d: got %h want %h", n, o, c.e); end
      n++;
    end
  endtask

  task automatic test_timeout(input kind_t k, input int wi, input int wd, input string tag);
    cyc_t c; obs_t o; int n = 0;
    add_instr(k, wi, wd, 0, 4'b0101);
    while (q.size() > 0) begin
      c = q.pop_front(); drive_cycle(c.s, o); n_tests++;
      if (o !== c.e) begin n_fail++; $display("FAIL %s cycle %0d: got %h want %h", tag, n, o, c.e); end
      n++;
    end
    test_reset(tag);
  endtask

  task automatic test_halt();
    cyc_t c; obs_t o; int n = 0;
    add_instr(K_HALT, 0, 0, 3, 4'h0);
    add_instr(K_HALT, 1, 0, 0, 4'h0);
    add_instr(K_FENCE, 0, 0, 0, 4'h0);
    while (q.size() > 0) begin
      c = q.pop_front(); drive_cycle(c.s, o); n_tests++;
      if (o !== c.e) begin n_fail++; $display("FAIL halt_resume cycle %0d: got %h want %h", n, o, c.e); end
      n++;
    end
  endtask

  task automatic test_random();
    cyc_t c; obs_t o; int n = 0;
    repeat (40) begin
      add_instr(kind_t'($urandom_range(0, 6)), $urandom_range(0, T - 1),
                $urandom_range(0, T - 1), $urandom_range(0, 3), 4'($urandom));
      while (q.size() > 0) begin
        c = q.pop_front(); drive_cycle(c.s, o); n_tests++;
        if (o !== c.e) begin n_fail++; $display("FAIL random cycle %0d: got %h want %h", n, o, c.e); end
        n++;
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    cyc_t c; obs_t o, e;
    add_instr(K_LOAD, 0, 3, 0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      c = q.pop_front(); drive_cycle(c.s, o); n_tests++;
      if (o !== c.e) begin n_fail++; $display("FAIL mid_mem_pre cycle %0d: got %h want %h", i, o, c.e); end
    end
    c = q.pop_front();
    q.delete();
    apply(c.s);
    #2;
    o = observe();
    n_tests++;
    if (o !== c.e) begin n_fail++; $display("FAIL mid_mem_req: got %h want %h", o, c.e); end
    test_reset("mid_mem");
    e = mk(S_IF, 1, 0, 0, 0, 4'h0);
    apply(garbage());
    @(negedge clk);
    o = observe();
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL mid_mem_after: got %h want %h", o, e); end
    @(posedge clk);
    #1 test_reset("mid_mem_clean");
  endtask

  initial begin
    apply('0);
    @(posedge clk);
    #1;
    test_reset("initial");
    test_alu();
    test_store_wait();
    test_imem_boundary();
    test_halt();
    test_random();
    test_timeout(K_LOAD, 0, 100, "dmem_timeout");
    test_timeout(K_ALU, 100, 0, "imem_timeout");
    test_timeout(K_ILL_HALT, 0, 0, "illegal_halt");
    test_timeout(K_ILL, 2, 0, "illegal");
    test_reset_mid_mem();
    test_alu();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
